// File: rtl/axi_rw_bridge_if.sv
// AXI4 read/write channel bundle between the bridge (master)
// and the memory subsystem (slave).
interface axi_rw_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [3:0]        arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;

    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [1:0]        bresp;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast,
        output rready,
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp,
        output bready
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast,
        input  rready,
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp,
        input  bready
    );
endinterface

// File: rtl/axi_rw_bridge.sv
// Arbitrates fetch and data requests onto a single-outstanding,
// single-beat 64-bit AXI4 master; completion is a one-cycle ready.
module axi_rw_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_rdata,
    input  logic              mem_valid,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_wdata,
    input  logic [7:0]        mem_strb,
    output logic              mem_ready,
    output logic [63:0]       mem_rdata,
    output logic              bus_err,
    axi_rw_bridge_if.master   axi
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_ADDR = 3'd1;
    localparam logic [2:0] RD_DATA = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] WR_RESP = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [63:0]       wdata_q;
    logic [7:0]        strb_q;
    logic              src_q;
    logic              err_q;
    logic              aw_done;
    logic              w_done;
    logic              aw_hs;
    logic              w_hs;
    logic              unused_bits;

    assign aw_hs = axi.awvalid & axi.awready;
    assign w_hs  = axi.wvalid & axi.wready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            src_q     <= 1'b0;
            err_q     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    err_q   <= 1'b0;
                    // data port wins over fetch
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        strb_q  <= mem_strb;
                        src_q   <= 1'b1;
                        state   <= mem_wr ? WR_REQ : RD_ADDR;
                    end else if (if_valid) begin
                        addr_q  <= if_addr;
                        wdata_q <= '0;
                        strb_q  <= '0;
                        src_q   <= 1'b0;
                        state   <= RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (axi.arready) state <= RD_DATA;
                end
                RD_DATA: begin
                    if (axi.rvalid) begin
                        err_q <= |axi.rresp;
                        if (src_q) mem_rdata <= axi.rdata;
                        else if_rdata <= addr_q[2] ? axi.rdata[63:32]
                                                   : axi.rdata[31:0];
                        state <= DONE;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs) w_done <= 1'b1;
                    if ((aw_done | aw_hs) & (w_done | w_hs))
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (axi.bvalid) begin
                        err_q <= |axi.bresp;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign axi.arvalid = (state == RD_ADDR);
    assign axi.araddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = 3'b011;
    assign axi.arburst = 2'b01;
    assign axi.rready  = (state == RD_DATA);

    assign axi.awvalid = (state == WR_REQ) & ~aw_done;
    assign axi.awaddr  = {addr_q[ADDR_W-1:3], 3'b000};
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = 3'b011;
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = (state == WR_REQ) & ~w_done;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = strb_q;
    assign axi.wlast   = 1'b1;
    assign axi.bready  = (state == WR_RESP);

    assign if_ready  = (state == DONE) & ~src_q;
    assign mem_ready = (state == DONE) & src_q;
    assign bus_err   = (state == DONE) & err_q;

    assign unused_bits = ^{axi.rlast, addr_q[1:0]};

endmodule

// File: tb/tb_axi_rw_bridge.sv
// Bench for axi_rw_bridge: AXI slave with programmable waits, a
// transaction-level model checked every cycle, and directed tests.
module tb_axi_rw_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_valid = 1'b0;
    logic [63:0] if_addr = '0;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        mem_valid = 1'b0;
    logic        mem_wr = 1'b0;
    logic [63:0] mem_addr = '0;
    logic [63:0] mem_wdata = '0;
    logic [7:0]  mem_strb = '0;
    logic        mem_ready;
    logic [63:0] mem_rdata;
    logic        bus_err;

    axi_rw_bridge_if #(.ADDR_W(64)) axi();

    axi_rw_bridge #(.AXI_ID(4'd0), .ADDR_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_valid  (if_valid),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .mem_valid (mem_valid),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_strb  (mem_strb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .bus_err   (bus_err),
        .axi       (axi)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // slave behaviour knobs, set by the directed tests
    int          ar_wait = 0;
    int          aw_wait = 0;
    int          w_wait = 0;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = 2'b00;
    logic [1:0]  b_resp = 2'b00;

    // observations published by the slave/model process
    int          aw_cnt = 0;
    int          w_cnt = 0;
    logic [63:0] last_araddr = '0;
    logic [63:0] last_awaddr = '0;
    logic [7:0]  last_wstrb = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Slave plus transaction model; inputs change at negedge only.
    initial begin : model
        bit          inflight, m_src, m_wr, resp_due, exp_err;
        bit          ar_done, aw_done, w_done, b_started;
        bit          r_pend, b_pend, ar_stall, aw_stall, w_stall;
        logic [63:0] m_addr, m_wdata, exp_mem;
        logic [7:0]  m_strb;
        logic [31:0] exp_if;
        int          arc, awc, wc;
        inflight = 0; m_src = 0; m_wr = 0; resp_due = 0; exp_err = 0;
        ar_done = 0; aw_done = 0; w_done = 0; b_started = 0;
        r_pend = 0; b_pend = 0; ar_stall = 0; aw_stall = 0; w_stall = 0;
        m_addr = '0; m_wdata = '0; m_strb = '0; exp_mem = '0; exp_if = '0;
        arc = 0; awc = 0; wc = 0;
        axi.arready = 0; axi.rvalid = 0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.bresp = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                inflight = 0; resp_due = 0; r_pend = 0; b_pend = 0;
                ar_stall = 0; aw_stall = 0; w_stall = 0;
                arc = 0; awc = 0; wc = 0;
                exp_mem = '0; exp_if = '0;
                axi.arready = 0; axi.rvalid = 0; axi.awready = 0;
                axi.wready = 0; axi.bvalid = 0;
            end else begin
                // completion must land exactly one cycle after R/B
                chk("if_ready", if_ready, resp_due && !m_src);
                chk("mem_ready", mem_ready, resp_due && m_src);
                chk("bus_err", bus_err, resp_due && exp_err);
                chk("if_rdata", if_rdata, exp_if);
                chk("mem_rdata", mem_rdata, exp_mem);
                if (resp_due) begin
                    resp_due = 0;
                    inflight = 0;
                end

                if ((axi.arvalid || axi.awvalid || axi.wvalid) && !inflight) begin
                    inflight = 1;
                    m_src = mem_valid;
                    m_wr = mem_valid && mem_wr;
                    m_addr = mem_valid ? mem_addr : if_addr;
                    m_wdata = mem_wdata;
                    m_strb = mem_strb;
                    ar_done = 0; aw_done = 0; w_done = 0; b_started = 0;
                end
                chk("one_channel", axi.arvalid && (axi.awvalid || axi.wvalid), 0);
                if (ar_stall) chk("ar_hold", axi.arvalid, 1);
                if (aw_stall) chk("aw_hold", axi.awvalid, 1);
                if (w_stall) chk("w_hold", axi.wvalid, 1);
                if (axi.arvalid) begin
                    chk("ar_is_read", m_wr, 0);
                    chk("araddr", axi.araddr, {m_addr[63:3], 3'b000});
                    chk("ar_fields", {axi.arid, axi.arlen, axi.arsize, axi.arburst},
                        {4'd0, 8'd0, 3'd3, 2'd1});
                    chk("ar_single", ar_done, 0);
                end
                if (axi.awvalid) begin
                    chk("aw_is_write", m_wr, 1);
                    chk("awaddr", axi.awaddr, {m_addr[63:3], 3'b000});
                    chk("aw_fields", {axi.awid, axi.awlen, axi.awsize, axi.awburst},
                        {4'd0, 8'd0, 3'd3, 2'd1});
                    chk("aw_single", aw_done, 0);
                end
                if (axi.wvalid) begin
                    chk("w_is_write", m_wr, 1);
                    chk("wdata", axi.wdata, m_wdata);
                    chk("wstrb", axi.wstrb, m_strb);
                    chk("wlast", axi.wlast, 1);
                    chk("w_single", w_done, 0);
                end

                axi.rvalid = r_pend;
                axi.rdata = r_data;
                axi.rresp = r_resp;
                axi.rlast = 1;
                if (r_pend && axi.rready) begin
                    r_pend = 0;
                    resp_due = 1;
                    exp_err = (r_resp != 2'b00);
                    if (m_src) exp_mem = r_data;
                    else exp_if = m_addr[2] ? r_data[63:32] : r_data[31:0];
                end
                axi.arready = 0;
                if (axi.arvalid && !ar_done) begin
                    if (arc >= ar_wait) begin
                        axi.arready = 1; arc = 0; ar_done = 1; r_pend = 1;
                        last_araddr = axi.araddr;
                    end else arc++;
                end
                ar_stall = axi.arvalid && !axi.arready;

                axi.bvalid = b_pend;
                axi.bresp = b_resp;
                if (b_pend && axi.bready) begin
                    b_pend = 0;
                    resp_due = 1;
                    exp_err = (b_resp != 2'b00);
                end
                axi.awready = 0;
                if (axi.awvalid && !aw_done) begin
                    if (awc >= aw_wait) begin
                        axi.awready = 1; awc = 0; aw_done = 1; aw_cnt++;
                        last_awaddr = axi.awaddr;
                    end else awc++;
                end
                aw_stall = axi.awvalid && !axi.awready;
                axi.wready = 0;
                if (axi.wvalid && !w_done) begin
                    if (wc >= w_wait) begin
                        axi.wready = 1; wc = 0; w_done = 1; w_cnt++;
                        last_wstrb = axi.wstrb;
                    end else wc++;
                end
                w_stall = axi.wvalid && !axi.wready;
                if (aw_done && w_done && !b_started) begin
                    b_started = 1;
                    b_pend = 1;
                end
            end
        end
    end

    // Latency counts cycles from the IDLE sampling edge to the ready cycle.
    task automatic req(input bit m, input bit wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] st,
                       output int lat, output bit e);
        @(posedge clk); #1;
        if (m) begin
            mem_valid = 1; mem_wr = wr; mem_addr = a;
            mem_wdata = wd; mem_strb = st;
        end else begin
            if_valid = 1; if_addr = a;
        end
        lat = -1;
        e = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (m ? mem_ready : if_ready) begin
                lat = n - 1;
                e = bus_err;
                break;
            end
        end
        @(posedge clk); #1;
        if (m) mem_valid = 0;
        else if_valid = 0;
    endtask

    initial begin : main
        int lat, nm, ni, a0, w0;
        bit e;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_if_ready", if_ready, 0);
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, '0);
        chk("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid}, 0);
        chk("rst_readies", {axi.rready, axi.bready}, 0);
        rst = 1;
        repeat (2) @(posedge clk);

        // fetch from the upper word
        r_data = 64'h11223344_55667788;
        req(0, 0, 64'h8000_0004, '0, '0, lat, e);
        chk("t1_lat", lat, 3);
        chk("t1_if_rdata", if_rdata, 32'h11223344);
        chk("t1_err", e, 0);
        chk("t1_araddr", last_araddr, 64'h8000_0000);

        // load and fetch together: load first, fetch 4 cycles later
        r_data = 64'hCAFEF00D_12345678;
        @(posedge clk); #1;
        mem_valid = 1; mem_wr = 0; mem_addr = 64'h8000_1000;
        if_valid = 1; if_addr = 64'h8000_0008;
        nm = -1;
        ni = -1;
        for (int n = 1; n <= 60 && ni < 0; n++) begin
            @(negedge clk);
            if (if_ready) ni = n;
            if (mem_ready) begin
                nm = n;
                @(posedge clk); #1;
                mem_valid = 0;
            end
        end
        @(posedge clk); #1;
        if_valid = 0;
        chk("t2_load_lat", nm - 1, 3);
        chk("t2_fetch_gap", ni - nm, 4);
        chk("t2_mem_rdata", mem_rdata, 64'hCAFEF00D_12345678);
        chk("t2_if_rdata", if_rdata, 32'h12345678);

        // store, W accepted two cycles after AW
        w_wait = 2;
        a0 = aw_cnt;
        w0 = w_cnt;
        req(1, 1, 64'h8000_2006, 64'h00AB_0000_0000_0000, 8'h40, lat, e);
        w_wait = 0;
        chk("t3_lat", lat, 5);
        chk("t3_aw_beats", aw_cnt - a0, 1);
        chk("t3_w_beats", w_cnt - w0, 1);
        chk("t3_awaddr", last_awaddr, 64'h8000_2000);
        chk("t3_wstrb", last_wstrb, 8'h40);
        chk("t3_err", e, 0);

        // zero-wait store with a DECERR response
        b_resp = 2'b11;
        req(1, 1, 64'h8000_2010, 64'h0123_4567_89AB_CDEF, 8'hFF, lat, e);
        b_resp = 2'b00;
        chk("t3b_lat", lat, 3);
        chk("t3b_err", e, 1);

        // load with SLVERR
        r_resp = 2'b10;
        r_data = 64'hDEADBEEF_0BADF00D;
        req(1, 0, 64'h8000_3010, '0, '0, lat, e);
        r_resp = 2'b00;
        chk("t4_lat", lat, 3);
        chk("t4_err", e, 1);
        chk("t4_mem_rdata", mem_rdata, 64'hDEADBEEF_0BADF00D);
        chk("t4_after", {mem_ready, bus_err}, 0);
        req(0, 0, 64'h8000_0020, '0, '0, lat, e);
        chk("t4_next_lat", lat, 3);
        chk("t4_next_rdata", if_rdata, 32'h0BADF00D);

        // reset while the read response is on the bus
        r_data = 64'h99999999_88888888;
        @(posedge clk); #1;
        if_valid = 1; if_addr = 64'h8000_0010;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t5_in_rd_data", axi.rready, 1);
        #1;
        rst = 0;
        #1;
        chk("t5_arvalid", axi.arvalid, 0);
        chk("t5_rready", axi.rready, 0);
        chk("t5_readies", {if_ready, mem_ready, bus_err}, 0);
        chk("t5_if_rdata", if_rdata, 0);
        @(posedge clk); #1;
        if_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
        r_data = 64'h55555555_AAAAAAAA;
        req(0, 0, 64'h8000_0014, '0, '0, lat, e);
        chk("t5_fetch_lat", lat, 3);
        chk("t5_fetch_rdata", if_rdata, 32'h55555555);

        // arready held off for ten cycles
        ar_wait = 10;
        r_data = 64'h01234567_89ABCDEF;
        req(0, 0, 64'h8000_4004, '0, '0, lat, e);
        ar_wait = 0;
        chk("t6_lat", lat, 13);
        chk("t6_araddr", last_araddr, 64'h8000_4000);
        chk("t6_if_rdata", if_rdata, 32'h01234567);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
